// File: rtl/rf_line_mover_pkg.sv
// Shared NPU types: default register-file geometry and the line-mover state
// encoding, also consumed by the control unit.
package rf_line_mover_pkg;
  localparam int RF_ADDR_W_DEF = 10;
  localparam int LINE_W_DEF    = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } mover_state_e;
endpackage

// File: rtl/rf_line_mover_if.sv
// Register-file port bundle: read request/data and write strobe/address/data.
interface rf_line_mover_if
  import rf_line_mover_pkg::*;
#(
  parameter int RF_ADDR_W = RF_ADDR_W_DEF,
  parameter int LINE_W    = LINE_W_DEF
);
  logic                 rf_rd_en;
  logic [RF_ADDR_W-1:0] rf_rd_addr;
  logic [LINE_W-1:0]    rf_rd_data;
  logic                 rf_wr_en;
  logic [RF_ADDR_W-1:0] rf_wr_addr;
  logic [LINE_W-1:0]    rf_wr_data;

  modport master (
    output rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
    input  rf_rd_data
  );
  modport slave (
    input  rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
    output rf_rd_data
  );
endinterface

// File: rtl/rf_line_mover_valid_pipe.sv
// Fixed-depth valid/payload delay line. inflight flags entries that will
// still be in the pipe after this cycle (all stages but the output one).
module valid_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  output logic         inflight
);
  logic [DEPTH-1:0]        vld_q, vld_d;
  logic [DEPTH-1:0][W-1:0] data_q, data_d;

  always_comb begin
    vld_d     = vld_q;
    data_d    = data_q;
    vld_d[0]  = in_vld;
    data_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
    inflight = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) inflight |= vld_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];
endmodule

// File: rtl/rf_line_mover.sv
// Copies move_line_num register-file lines from src to dst at one line per
// cycle; each read becomes a write RD_LAT cycles later via the delay line.
module rf_line_mover
  import rf_line_mover_pkg::*;
#(
  parameter int RF_ADDR_W = RF_ADDR_W_DEF,
  parameter int LINE_W    = LINE_W_DEF,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 move_start,
  input  logic [RF_ADDR_W-1:0] move_src_addr,
  input  logic [RF_ADDR_W-1:0] move_dst_addr,
  input  logic [7:0]           move_line_num,
  output logic                 busy,
  output logic                 done,
  rf_line_mover_if.master      rf
);
  mover_state_e         state_q, state_d;
  logic [RF_ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 zero_q, zero_d, late_done_q, late_done_d;
  logic                 rd_en, inflight;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    late_done_d = 1'b0;
    rd_en       = 1'b0;
    busy        = (state_q != ST_IDLE);
    done        = late_done_q;
    case (state_q)
      ST_IDLE: if (move_start) begin
        rd_addr_d = move_src_addr;
        wr_addr_d = move_dst_addr;
        cnt_d     = move_line_num;
        zero_d    = (move_line_num == 8'd0);
        state_d   = (move_line_num == 8'd0) ? ST_DONE : ST_READ;
      end
      ST_READ: begin
        rd_en     = 1'b1;
        rd_addr_d = rd_addr_q + RF_ADDR_W'(1);
        wr_addr_d = wr_addr_q + RF_ADDR_W'(1);
        cnt_d     = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = ST_DRAIN;
      end
      // Leave once only the output stage can still hold the final write.
      ST_DRAIN: if (!inflight) state_d = ST_DONE;
      ST_DONE: begin
        // An empty move reports completion one cycle late, after busy drops.
        done        = ~zero_q;
        late_done_d = zero_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      late_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      late_done_q <= late_done_d;
    end
  end

  valid_pipe #(.DEPTH(RD_LAT), .W(RF_ADDR_W)) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (rd_en),
    .in_data  (wr_addr_q),
    .out_vld  (rf.rf_wr_en),
    .out_data (rf.rf_wr_addr),
    .inflight (inflight)
  );

  assign rf.rf_rd_en   = rd_en;
  assign rf.rf_rd_addr = rd_addr_q;
  assign rf.rf_wr_data = rf.rf_rd_data;
endmodule
